// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard modes and helpers.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_800x600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1}
  };

  localparam vga_mode_t VGA_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0},
    v: '{active: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b0}
  };

  // Pixels per line or lines per frame for one axis.
  function automatic int unsigned total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to align sync/blank with a pixel pipeline.
module sync_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clock, reset_n, enable};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per enabled clock; hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (enable) begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered outputs and an
// aligned, delayed copy of HS/VS/blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_800x600_60.h.active,
  parameter int unsigned H_FP       = VGA_800x600_60.h.fp,
  parameter int unsigned H_SYNC     = VGA_800x600_60.h.sync,
  parameter int unsigned H_BP       = VGA_800x600_60.h.bp,
  parameter int unsigned V_ACTIVE   = VGA_800x600_60.v.active,
  parameter int unsigned V_FP       = VGA_800x600_60.v.fp,
  parameter int unsigned V_SYNC     = VGA_800x600_60.v.sync,
  parameter int unsigned V_BP       = VGA_800x600_60.v.bp,
  parameter logic        HS_POL     = VGA_800x600_60.h.pol,
  parameter logic        VS_POL     = VGA_800x600_60.v.pol,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned CW         = 11
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          HS,
  output logic          VS,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          HS_d,
  output logic          VS_d,
  output logic          blank_d
);

  localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: HS_POL};
  localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: VS_POL};
  localparam int unsigned H_TOTAL = total(H_T);
  localparam int unsigned V_TOTAL = total(V_T);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_h_width_err
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_v_width_err
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end
  if (PIPE_DELAY > 15) begin : g_pipe_err
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          blank_nxt;

  // Next pixel position and its decode; outputs register these so every
  // output describes the same pixel as col/row.
  always_comb begin
    col_nxt = col + 1'b1;
    row_nxt = row;
    if (col == H_LAST) begin
      col_nxt = '0;
      row_nxt = (row == V_LAST) ? '0 : row + 1'b1;
    end
    hs_nxt    = (32'(col_nxt) >= HS_START && 32'(col_nxt) < HS_END) ? HS_POL : ~HS_POL;
    vs_nxt    = (32'(row_nxt) >= VS_START && 32'(row_nxt) < VS_END) ? VS_POL : ~VS_POL;
    blank_nxt = !(32'(col_nxt) < H_ACTIVE && 32'(row_nxt) < V_ACTIVE);
  end

  // Timing state; pulses are cleared while frozen so they never repeat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col         <= '0;
      row         <= '0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      col         <= col_nxt;
      row         <= row_nxt;
      HS          <= hs_nxt;
      VS          <= vs_nxt;
      blank       <= blank_nxt;
      line_start  <= (col_nxt == '0);
      frame_start <= (col_nxt == '0) && (row_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ({~HS_POL, ~VS_POL, 1'b1})
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .din     ({HS, VS, blank}),
    .dout    ({HS_d, VS_d, blank_d})
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u_d: default 800x600, PIPE_DELAY=1
  logic rst_d = 1'b0, en_d = 1'b0;
  logic [10:0] d_col, d_row;
  logic d_hs, d_vs, d_bl, d_ls, d_fs, d_hsd, d_vsd, d_bld;
  vga_timing_gen u_d (
    .clock(clk), .reset_n(rst_d), .enable(en_d), .col(d_col), .row(d_row),
    .HS(d_hs), .VS(d_vs), .blank(d_bl), .line_start(d_ls), .frame_start(d_fs),
    .HS_d(d_hsd), .VS_d(d_vsd), .blank_d(d_bld));

  // u_s3 / u_s0: tiny frame (23 x 11), active-high, PIPE_DELAY 3 and 0
  logic rst_s = 1'b0, en_s = 1'b0;
  logic [10:0] s3_col, s3_row, s0_col, s0_row;
  logic s3_hs, s3_vs, s3_bl, s3_ls, s3_fs, s3_hsd, s3_vsd, s3_bld;
  logic s0_hs, s0_vs, s0_bl, s0_ls, s0_fs, s0_hsd, s0_vsd, s0_bld;
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(3), .CW(11)
  ) u_s3 (
    .clock(clk), .reset_n(rst_s), .enable(en_s), .col(s3_col), .row(s3_row),
    .HS(s3_hs), .VS(s3_vs), .blank(s3_bl), .line_start(s3_ls), .frame_start(s3_fs),
    .HS_d(s3_hsd), .VS_d(s3_vsd), .blank_d(s3_bld));
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(0), .CW(11)
  ) u_s0 (
    .clock(clk), .reset_n(rst_s), .enable(en_s), .col(s0_col), .row(s0_row),
    .HS(s0_hs), .VS(s0_vs), .blank(s0_bl), .line_start(s0_ls), .frame_start(s0_fs),
    .HS_d(s0_hsd), .VS_d(s0_vsd), .blank_d(s0_bld));

  // u_g: 640-wide line (16/96/48), short frame 8/2/2/3, active-low syncs
  logic rst_g = 1'b0, en_g = 1'b0;
  logic [10:0] g_col, g_row;
  logic g_hs, g_vs, g_bl, g_ls, g_fs, g_hsd, g_vsd, g_bld;
  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(2), .CW(11)
  ) u_g (
    .clock(clk), .reset_n(rst_g), .enable(en_g), .col(g_col), .row(g_row),
    .HS(g_hs), .VS(g_vs), .blank(g_bl), .line_start(g_ls), .frame_start(g_fs),
    .HS_d(g_hsd), .VS_d(g_vsd), .blank_d(g_bld));

  // Reference decode for the tiny frame: {HS, VS, blank}
  function automatic logic [2:0] dec_small(input int c, input int r);
    logic hs, vs, bl;
    hs = (c >= 18 && c < 21);
    vs = (r >= 7 && r < 9);
    bl = !(c < 16 && r < 6);
    return {hs, vs, bl};
  endfunction

  initial begin
    int mis, hs_n, hs_first, hs_last, bl_n, ls_n;
    int mc, mr, vs_n, fs_n, last_fs, period;
    int cnt_mis, sig_mis, d3_mis, d0_mis, pulse_mis;
    int vs_first, vs_last, r;
    logic [2:0] e_cur;
    logic [2:0] st [3];

    repeat (5) tick();

    // ---------------- default 800x600 ----------------
    check("rst_col", d_col, 0);
    check("rst_row", d_row, 0);
    check("rst_hs", d_hs, 0);
    check("rst_vs", d_vs, 0);
    check("rst_blank", d_bl, 0);
    check("rst_blank_d", d_bld, 1);
    check("rst_hs_d", d_hsd, 0);
    check("rst_line_start", d_ls, 0);

    rst_d = 1'b1; en_d = 1'b1;
    tick();
    check("first_col", d_col, 1);
    check("first_row", d_row, 0);

    mis = 0; hs_n = 0; hs_first = -1; hs_last = -1; bl_n = 0; ls_n = 0;
    for (int c = 1; c <= 1055; c++) begin
      if (d_col != c || d_row != 0) mis++;
      if (d_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (d_bl) bl_n++;
      if (d_ls || d_fs) ls_n++;
      if (c < 1055) tick();
    end
    check("line_pos_mis", mis, 0);
    check("hs_width", hs_n, 128);
    check("hs_first", hs_first, 840);
    check("hs_last", hs_last, 967);
    check("blank_cycles", bl_n, 256);
    check("no_pulse_in_line", ls_n, 0);

    // Freeze at col 1055
    en_d = 1'b0;
    mis = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_col != 1055 || d_row != 0 || d_hs != 0 || d_vs != 0 || d_bl != 1 ||
          d_ls != 0 || d_fs != 0 || d_hsd != 0 || d_vsd != 0 || d_bld != 1) mis++;
    end
    check("freeze_mis", mis, 0);

    en_d = 1'b1;
    tick();
    check("wrap_col", d_col, 0);
    check("wrap_row", d_row, 1);
    check("wrap_line_start", d_ls, 1);
    check("wrap_frame_start", d_fs, 0);
    check("wrap_blank", d_bl, 0);
    tick();
    check("line_start_once", d_ls, 0);
    check("after_wrap_col", d_col, 1);

    // ---------------- tiny frame, delay 3 and 0 ----------------
    rst_s = 1'b1; en_s = 1'b1;
    mc = 0; mr = 0;
    e_cur = 3'b000;
    for (int i = 0; i < 3; i++) st[i] = 3'b001;
    cnt_mis = 0; sig_mis = 0; d3_mis = 0; d0_mis = 0; pulse_mis = 0;
    vs_n = 0; hs_n = 0; fs_n = 0; last_fs = -1; period = 0;
    for (int k = 1; k <= 507; k++) begin
      tick();
      st[2] = st[1]; st[1] = st[0]; st[0] = e_cur;
      if (mc == 22) begin
        mc = 0;
        mr = (mr == 10) ? 0 : mr + 1;
      end else begin
        mc++;
      end
      e_cur = dec_small(mc, mr);
      if (s3_col != mc || s3_row != mr || s0_col != mc || s0_row != mr) cnt_mis++;
      if ({s3_hs, s3_vs, s3_bl} != e_cur || {s0_hs, s0_vs, s0_bl} != e_cur) sig_mis++;
      if ({s3_hsd, s3_vsd, s3_bld} != st[2]) d3_mis++;
      if ({s0_hsd, s0_vsd, s0_bld} != e_cur) d0_mis++;
      if (s3_ls != (mc == 0) || s3_fs != (mc == 0 && mr == 0) ||
          s0_ls != (mc == 0) || s0_fs != (mc == 0 && mr == 0)) pulse_mis++;
      if (s3_vs) vs_n++;
      if (s3_hs) hs_n++;
      if (s3_fs) begin
        fs_n++;
        if (last_fs >= 0) period = k - last_fs;
        last_fs = k;
      end
    end
    check("small_counter_mis", cnt_mis, 0);
    check("small_decode_mis", sig_mis, 0);
    check("delay3_mis", d3_mis, 0);
    check("delay0_mis", d0_mis, 0);
    check("small_pulse_mis", pulse_mis, 0);
    check("small_vs_cycles", vs_n, 92);
    check("small_hs_cycles", hs_n, 66);
    check("small_frame_starts", fs_n, 2);
    check("small_frame_period", period, 253);

    // ---------------- 640-wide, active-low ----------------
    rst_g = 1'b1; en_g = 1'b1;
    tick();
    mis = 0; hs_n = 0; hs_first = -1; hs_last = -1;
    for (int c = 1; c <= 799; c++) begin
      if (g_col != c || g_row != 0) mis++;
      if (!g_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      tick();
    end
    check("g_line_pos_mis", mis, 0);
    check("g_hs_low_width", hs_n, 96);
    check("g_hs_first", hs_first, 656);
    check("g_hs_last", hs_last, 751);
    check("g_wrap_col", g_col, 0);
    check("g_wrap_row", g_row, 1);

    vs_n = 0; vs_first = -1; vs_last = -1;
    for (int k = 0; k < 11200; k++) begin
      r = k / 800 + 1;
      if (!g_vs) begin
        vs_n++;
        if (vs_first < 0) vs_first = r;
        vs_last = r;
      end
      tick();
    end
    check("g_vs_low_cycles", vs_n, 1600);
    check("g_vs_first_row", vs_first, 10);
    check("g_vs_last_row", vs_last, 11);
    check("g_frame_wrap_row", g_row, 0);
    check("g_frame_wrap_col", g_col, 0);
    check("g_frame_start", g_fs, 1);

    repeat (300) tick();
    check("g_pre_reset_col", g_col, 300);

    // Asynchronous reset between clock edges
    #3;
    rst_g = 1'b0;
    #1;
    check("async_rst_col", g_col, 0);
    check("async_rst_row", g_row, 0);
    check("async_rst_hs", g_hs, 1);
    check("async_rst_vs", g_vs, 1);
    check("async_rst_blank", g_bl, 0);
    check("async_rst_blank_d", g_bld, 1);
    check("async_rst_hs_d", g_hsd, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA timing generator.
- Resolution, porch/sync widths and sync polarity are parameters.
- Adds a built-in, configurable delay line that aligns HS/VS/blank to a pixel pipeline of any depth. This replaces ad-hoc delay registers in the top level.
- Sits between the pixel clock domain (40 MHz) and the renderer/HDMI transmitter.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- HS_POL, 1, HS active level (1 = active-high)
- VS_POL, 1, VS active level
- PIPE_DELAY, 1, cycles of delay on HS_d/VS_d/blank_d (0..15)
- CW, 11, row/col counter width

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = advance timing; 0 = freeze all state
- col  out  CW  current horizontal position
- row  out  CW  current vertical position
- HS  out  1  horizontal sync, aligned with row/col
- VS  out  1  vertical sync, aligned with row/col
- blank  out  1  1 outside the active region, aligned with row/col
- line_start  out  1  one-cycle pulse when col==0
- frame_start  out  1  one-cycle pulse when row==0 && col==0
- HS_d  out  1  HS delayed PIPE_DELAY cycles
- VS_d  out  1  VS delayed PIPE_DELAY cycles
- blank_d  out  1  blank delayed PIPE_DELAY cycles

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL likewise (default 628).
- Reset values:
  - col=0, row=0, line_start=0, frame_start=0.
  - HS=~HS_POL, VS=~VS_POL, blank=0.
  - Every delay-line stage: HS=~HS_POL, VS=~VS_POL, blank=1.
- Reset is asynchronous-assert; deassertion takes effect on the next clock edge.
- Counter, per enabled clock:
  - If col==H_TOTAL-1: col←0; row←(row==V_TOTAL-1) ? 0 : row+1.
  - Otherwise col←col+1.
- All outputs are registered and decoded from the next-state counter values, so col, row, HS, VS, blank and the pulses describe the same pixel in the same cycle. No combinational output paths.
- Decode:
  - blank = !(col<H_ACTIVE && row<V_ACTIVE).
  - HS = HS_POL when H_ACTIVE+H_FP ≤ col < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - VS = VS_POL when V_ACTIVE+V_FP ≤ row < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. VS changes with the row, at col==0.
- The first cycle after reset release with enable=1 presents col=1. col=0 of row 0 is the reset state itself; line_start/frame_start first pulse at the next wrap.
- enable=0:
  - Counters, decoded outputs and the delay line all hold.
  - line_start and frame_start are forced to 0, so a held pulse never repeats.
- Delay line:
  - PIPE_DELAY=N≥1: HS_d/VS_d/blank_d equal HS/VS/blank from N enabled cycles earlier. Shift only when enable=1.
  - PIPE_DELAY=0: pass-through wires from the registered HS/VS/blank.
- Reset mid-frame: immediate return to reset values; no partial-line completion.
- Width rule: elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if PIPE_DELAY>15. Comparisons are unsigned at CW bits.

Decomposition:
- Package vga_pkg holds:
  - typedef struct vga_timing_t (active, fp, sync, bp, pol).
  - localparam constants VGA_800x600_60 and VGA_640x480_60.
  - function total() returning the line/frame totals.
- One sub-module, sync_delay_line (parameters WIDTH, DEPTH, RESET_VAL; enable input), instantiated once with WIDTH=3 for {HS,VS,blank}.

Test Plan:
- Reset, then hold reset_n=0 for 5 cycles → col=0, row=0, HS=0, VS=0, blank=0, blank_d=1; release plus 1 clock → col=1.
- Run one line with defaults:
  - HS=1 exactly for col 840..967 (128 cycles).
  - blank=1 for col 800..1055.
  - col 1055→0 with row 0→1; line_start=1 for that single cycle.
- Run a full frame:
  - VS=1 exactly for rows 601..604.
  - Wrap row 627 / col 1055 → row 0 / col 0; frame_start=1 for one cycle.
  - Frame period is 663,168 clocks.
- PIPE_DELAY=3 → HS_d/VS_d/blank_d are bit-exact copies of HS/VS/blank shifted 3 cycles over a full frame. PIPE_DELAY=0 → identical to the undelayed signals.
- Drop enable for 10 cycles at col=1055 → all outputs frozen, no line_start. Re-enable → col=0, row+1, line_start pulses exactly once.
- HS_POL=0, VS_POL=0, 640x480 (16/96/48, 10/2/33):
  - HS=0 for col 656..751, else 1.
  - VS=0 for rows 490..491.
  - Assert reset_n=0 mid-line at col 300 → col=0 with no clock edge required.
